io_arbiter: RTL and testbench



---
 rtl/io_arb_pkg.sv | 14 +
 rtl/if_io.sv | 15 +
 rtl/io_arbiter_rr_pick.sv | 33 +++
 rtl/io_arbiter.sv | 141 ++++++++++++++
 tb/tb_io_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_arb_pkg.sv
// rtl/io_arb_pkg.sv - shared types and limits for the J1 I/O bus arbiter
// Contents: state_t  arbiter FSM states
//           NREQ_MAX largest supported requester count
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_MAX = 8;

endpackage

// File: rtl/if_io.sv
// rtl/if_io.sv - J1 I/O slave bus (OR-bus read data, single-cycle strobes)
// Signals: addr  16  I/O address
//          dout  16  write data from master
//          din   16  read data to master, zero when no slave is read
//          rd/wr  1  single-cycle read/write strobes
interface if_io;
  logic [15:0] addr;
  logic [15:0] dout;
  logic [15:0] din;
  logic        rd;
  logic        wr;

  modport master (output addr, output dout, output rd, output wr, input din);
  modport slave  (input addr, input dout, input rd, input wr, output din);
endinterface

// File: rtl/io_arbiter_rr_pick.sv
// rtl/io_arbiter_rr_pick.sv - combinational winner select, round-robin or fixed priority
// Ports: elig   NREQ  eligible request vector
//        ptr    IDXW  round-robin search start (ignored when FIXED_PRIO != 0)
//        valid  1     some request is eligible
//        idx    IDXW  winning requester index
module rr_pick #(
  parameter  int NREQ       = 2,
  parameter  int FIXED_PRIO = 0,
  localparam int IDXW       = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;

  // Scan from the farthest candidate toward the preferred one so the last
  // hit (the highest-priority one) is what remains in idx.
  always_comb begin
    valid = |elig;
    idx   = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = (FIXED_PRIO != 0) ? IDXW'(i) : IDXW'((int'(ptr) + i) % NREQ);
      if (elig[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - shares one J1 I/O slave bus among NREQ requesters
// Ports: clk, reset  clock, synchronous active-high reset
//        req/we      NREQ       request and write flag per requester
//        addr/wdata  NREQ x 16  address and write data per requester
//        ack         NREQ       one-cycle completion pulse
//        rdata       16         read data, valid with ack, zero otherwise
//        io          if_io      registered bus strobes, address and data
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ-1:0][15:0] addr,
  input  logic [NREQ-1:0][15:0] wdata,
  output logic [NREQ-1:0]       ack,
  output logic [15:0]           rdata,
  if_io.master                  io
);

  localparam int IDXW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_nreq_range
    $error("io_arbiter: NREQ out of range");
  end

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;

  logic [NREQ-1:0] elig;
  logic [IDXW-1:0] ptr_next;
  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;
  logic            launch;

  assign ptr_next = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

  // The requester being acked still has req high in DONE; hide it so the
  // same request is not served twice.
  always_comb begin
    elig = req;
    if (state_q == DONE) begin
      elig[idx_q] = 1'b0;
    end
  end

  rr_pick #(
    .NREQ       (NREQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .elig  (elig),
    .ptr   ((state_q == DONE) ? ptr_next : ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    ack_d   = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    launch  = 1'b0;

    case (state_q)
      IDLE: begin
        launch = pick_valid;
      end
      BUS: begin
        rdata_d       = io.din;
        ack_d[idx_q]  = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        ptr_d   = ptr_next;
        state_d = IDLE;
        launch  = pick_valid;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are registered on entry to BUS so they are clean one-cycle pulses.
    if (launch) begin
      state_d = BUS;
      idx_d   = pick_idx;
      addr_d  = addr[pick_idx];
      wdata_d = wdata[pick_idx];
      rd_d    = ~we[pick_idx];
      wr_d    = we[pick_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign io.addr = addr_q;
  assign io.dout = wdata_q;
  assign io.rd   = rd_q;
  assign io.wr   = wr_q;

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - self-checking bench for io_arbiter
module tb_io_arbiter;

  localparam logic [15:0] LEDG = 16'h0010;
  localparam logic [15:0] SW   = 16'h0020;

  typedef struct {
    int          idx;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } xfer_t;

  logic clk;
  logic reset;

  // Round-robin instance, two requesters
  logic [1:0]       req, we, ack;
  logic [1:0][15:0] addr, wdata;
  logic [15:0]      rdata;
  logic [9:0]       sw;
  logic [7:0]       ledg;
  if_io bus_rr ();

  // Fixed-priority instance, three requesters
  logic [2:0]       f_req, f_we, f_ack;
  logic [2:0][15:0] f_addr, f_wdata;
  logic [15:0]      f_rdata;
  if_io bus_fx ();

  xfer_t exp_bus[$];
  xfer_t exp_ack[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic  prev_strobe = 1'b0;

  io_arbiter #(.NREQ(2), .FIXED_PRIO(0)) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .io    (bus_rr)
  );

  io_arbiter #(.NREQ(3), .FIXED_PRIO(1)) u_fx (
    .clk   (clk),
    .reset (reset),
    .req   (f_req),
    .we    (f_we),
    .addr  (f_addr),
    .wdata (f_wdata),
    .ack   (f_ack),
    .rdata (f_rdata),
    .io    (bus_fx)
  );

  // Board slave models: SW switch input, LEDG register, other addresses read addr^5A5A.
  assign bus_rr.din = !bus_rr.rd ? 16'h0000 :
                      (bus_rr.addr == SW) ? {6'b0, sw} : (bus_rr.addr ^ 16'h5A5A);
  assign bus_fx.din = bus_fx.rd ? (bus_fx.addr ^ 16'h5A5A) : 16'h0000;

  always_ff @(posedge clk) begin
    if (reset) ledg <= 8'h00;
    else if (bus_rr.wr && bus_rr.addr == LEDG) ledg <= bus_rr.dout[7:0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  task automatic push_xfer(input int idx, input logic w, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] rd, input bit with_ack);
    xfer_t e;
    e.idx = idx; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
    exp_bus.push_back(e);
    if (with_ack) exp_ack.push_back(e);
  endtask

  // Advance to the next falling edge and retire any bus strobe / ack against the scoreboard.
  task automatic step_score();
    xfer_t e;
    @(negedge clk);
    cyc++;
    if (bus_rr.wr || bus_rr.rd) begin
      n_cmp++;
      if (prev_strobe) begin
        n_fail++;
        $display("FAIL strobe_consecutive: strobe high two cycles at cycle %0d, required single pulse", cyc);
      end
      n_cmp++;
      if (exp_bus.size() == 0) begin
        n_fail++;
        $display("FAIL bus_unexpected: rd=%b wr=%b addr=%h, required no strobe", bus_rr.rd, bus_rr.wr, bus_rr.addr);
      end else begin
        e = exp_bus.pop_front();
        if ({bus_rr.wr, bus_rr.rd, bus_rr.addr, (bus_rr.wr ? bus_rr.dout : 16'h0)} !==
            {e.we, ~e.we, e.addr, (e.we ? e.wdata : 16'h0)}) begin
          n_fail++;
          $display("FAIL bus_xfer: wr=%b rd=%b addr=%h dout=%h, required wr=%b addr=%h dout=%h",
                   bus_rr.wr, bus_rr.rd, bus_rr.addr, bus_rr.dout, e.we, e.addr, e.wdata);
        end
      end
    end
    prev_strobe = bus_rr.wr | bus_rr.rd;
    n_cmp++;
    if (ack !== 2'b00) begin
      if (exp_ack.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: ack=%b, required 00", ack);
      end else begin
        e = exp_ack.pop_front();
        if (ack !== (2'b01 << e.idx) || rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL ack_data: ack=%b rdata=%h, required ack=%b rdata=%h",
                   ack, rdata, 2'b01 << e.idx, e.rdata);
        end
      end
    end else if (rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rdata_idle: rdata=%h, required 0000", rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step_score();
    step_score();
    n_cmp++;
    if ({ack, rdata, bus_rr.rd, bus_rr.wr, bus_rr.addr, bus_rr.dout} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_rr: ack=%b rdata=%h rd=%b wr=%b addr=%h dout=%h, required all zero",
               ack, rdata, bus_rr.rd, bus_rr.wr, bus_rr.addr, bus_rr.dout);
    end
    n_cmp++;
    if ({f_ack, f_rdata, bus_fx.rd, bus_fx.wr, bus_fx.addr, bus_fx.dout} !== 53'h0) begin
      n_fail++;
      $display("FAIL reset_fx: ack=%b rdata=%h rd=%b wr=%b, required all zero",
               f_ack, f_rdata, bus_fx.rd, bus_fx.wr);
    end
    reset = 1'b0;
    step_score();
  endtask

  task automatic test_single_write();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = LEDG; wdata[0] = 16'h00A5;
    push_xfer(0, 1'b1, LEDG, 16'h00A5, 16'h0000, 1'b1);
    step_score();
    n_cmp++;
    if (bus_rr.wr !== 1'b1) begin
      n_fail++;
      $display("FAIL write_latency: wr=%b one cycle after req, required 1", bus_rr.wr);
    end
    step_score();
    n_cmp++;
    if (ack !== 2'b01) begin
      n_fail++;
      $display("FAIL write_ack: ack=%b two cycles after req, required 01", ack);
    end
    req[0] = 1'b0;
    step_score();
    n_cmp++;
    if (ledg !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_ledg: ledg=%h, required a5", ledg);
    end
  endtask

  task automatic test_single_read();
    sw = 10'h2C3;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = SW; wdata[1] = 16'hFFFF;
    push_xfer(1, 1'b0, SW, 16'hFFFF, 16'h02C3, 1'b1);
    step_score();
    n_cmp++;
    if (bus_rr.rd !== 1'b1 || bus_rr.wr !== 1'b0) begin
      n_fail++;
      $display("FAIL read_strobe: rd=%b wr=%b, required rd=1 wr=0", bus_rr.rd, bus_rr.wr);
    end
    step_score();
    n_cmp++;
    if (ack !== 2'b10 || rdata !== 16'h02C3) begin
      n_fail++;
      $display("FAIL read_ack: ack=%b rdata=%h, required ack=10 rdata=02c3", ack, rdata);
    end
    req[1] = 1'b0;
    step_score();
    n_cmp++;
    if (rdata !== 16'h0000 || ack !== 2'b00) begin
      n_fail++;
      $display("FAIL read_after: ack=%b rdata=%h, required 00 / 0000", ack, rdata);
    end
  endtask

  task automatic test_contention_rr();
    int acks = 0;
    int last = -1;
    we = 2'b00; addr[0] = 16'h0100; addr[1] = 16'h0200;
    for (int k = 0; k < 8; k++) begin
      push_xfer(k % 2, 1'b0, addr[k % 2], wdata[k % 2], addr[k % 2] ^ 16'h5A5A, 1'b1);
    end
    req = 2'b11;
    for (int t = 0; t < 40 && acks < 8; t++) begin
      step_score();
      if (ack !== 2'b00) begin
        acks++;
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != 2) begin
            n_fail++;
            $display("FAIL rr_spacing: ack gap %0d cycles, required 2", cyc - last);
          end
        end
        last = cyc;
        if (acks == 7) req[0] = 1'b0;
        if (acks == 8) req[1] = 1'b0;
      end
    end
    n_cmp++;
    if (acks != 8) begin
      n_fail++;
      $display("FAIL rr_timeout: %0d acks seen, required 8", acks);
      req = 2'b00;
    end
    step_score();
    step_score();
  endtask

  task automatic test_back_to_back();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = LEDG; wdata[0] = 16'h0011;
    push_xfer(0, 1'b1, LEDG, 16'h0011, 16'h0000, 1'b1);
    step_score();
    step_score();
    n_cmp++;
    if (ack !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_first_ack: ack=%b, required 01", ack);
    end
    wdata[0] = 16'h0022;
    push_xfer(0, 1'b1, LEDG, 16'h0022, 16'h0000, 1'b1);
    step_score();
    n_cmp++;
    if (bus_rr.wr !== 1'b0 || bus_rr.rd !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_resample: wr=%b rd=%b right after ack, required 0 0", bus_rr.wr, bus_rr.rd);
    end
    step_score();
    n_cmp++;
    if (bus_rr.wr !== 1'b1 || bus_rr.dout !== 16'h0022) begin
      n_fail++;
      $display("FAIL b2b_second: wr=%b dout=%h, required 1 / 0022", bus_rr.wr, bus_rr.dout);
    end
    step_score();
    req[0] = 1'b0;
    step_score();
    step_score();
  endtask

  task automatic test_fixed_prio();
    int  cnt0 = 0;
    bit  got2 = 1'b0;
    f_we = 3'b000;
    for (int i = 0; i < 3; i++) f_addr[i] = 16'h0500 + 16'(i);
    f_req = 3'b110;
    step_score();
    step_score();
    n_cmp++;
    if (f_ack !== 3'b010 || f_rdata !== (16'h0501 ^ 16'h5A5A)) begin
      n_fail++;
      $display("FAIL fx_lowest: ack=%b rdata=%h, required 010 / %h", f_ack, f_rdata, 16'h0501 ^ 16'h5A5A);
    end
    f_req = 3'b100;
    step_score();
    step_score();
    n_cmp++;
    if (f_ack !== 3'b100 || f_rdata !== (16'h0502 ^ 16'h5A5A)) begin
      n_fail++;
      $display("FAIL fx_next: ack=%b rdata=%h, required 100 / %h", f_ack, f_rdata, 16'h0502 ^ 16'h5A5A);
    end
    f_req = 3'b000;
    step_score();
    f_req = 3'b111;
    for (int t = 1; t <= 12; t++) begin
      step_score();
      n_cmp++;
      if (f_ack[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL fx_starve: ack=%b at step %0d, required bit2 low", f_ack, t);
      end
      if (f_ack[0] === 1'b1) cnt0++;
    end
    n_cmp++;
    if (cnt0 != 3) begin
      n_fail++;
      $display("FAIL fx_count0: %0d acks of req0 in 12 cycles, required 3", cnt0);
    end
    if (f_ack[0] === 1'b1) f_req[0] = 1'b0;
    if (f_ack[1] === 1'b1) f_req[1] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step_score();
      if (f_ack[0] === 1'b1) f_req[0] = 1'b0;
      if (f_ack[1] === 1'b1) f_req[1] = 1'b0;
      if (f_ack[2] === 1'b1) begin
        got2 = 1'b1;
        f_req[2] = 1'b0;
        break;
      end
    end
    n_cmp++;
    if (!got2) begin
      n_fail++;
      $display("FAIL fx_drain: req2 not acked after higher requesters dropped, required ack");
      f_req = 3'b000;
    end
    step_score();
    step_score();
  endtask

  task automatic test_reset_in_bus();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0300; wdata[0] = 16'h1234;
    push_xfer(0, 1'b1, 16'h0300, 16'h1234, 16'h0000, 1'b0);
    step_score();
    n_cmp++;
    if (bus_rr.wr !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_bus_setup: wr=%b, required 1", bus_rr.wr);
    end
    reset = 1'b1;
    step_score();
    n_cmp++;
    if (bus_rr.wr !== 1'b0 || ack !== 2'b00 || bus_rr.addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_abort: wr=%b ack=%b addr=%h, required 0 / 00 / 0000", bus_rr.wr, ack, bus_rr.addr);
    end
    reset = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0400;
    push_xfer(0, 1'b1, 16'h0300, 16'h1234, 16'h0000, 1'b1);
    push_xfer(1, 1'b0, 16'h0400, wdata[1], 16'h0400 ^ 16'h5A5A, 1'b1);
    step_score();
    step_score();
    n_cmp++;
    if (ack !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_ptr: first ack after reset=%b, required 01", ack);
    end
    req[0] = 1'b0;
    step_score();
    step_score();
    req[1] = 1'b0;
    step_score();
    step_score();
  endtask

  initial begin
    reset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; sw = '0;
    f_req = '0; f_we = '0; f_addr = '0; f_wdata = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention_rr();
    test_back_to_back();
    test_fixed_prio();
    test_reset_in_bus();
    n_cmp++;
    if (exp_bus.size() != 0 || exp_ack.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d bus / %0d ack entries left, required 0 / 0",
               exp_bus.size(), exp_ack.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
